key_event_gen: RTL and testbench
================================

KEY_EVENT_GEN -- requirements
Module: key_event_gen

Interface
REQ-001 Parameter CLK_DIV, default 100000, clk cycles per 1 ms tick; legal range >=2.
REQ-002 Parameter LONG_MS, default 800, hold time in ms before a long-press event; legal range >=1.
REQ-003 Parameter REPEAT_MS, default 150, auto-repeat interval in ms after a long press; legal range >=1.
REQ-004 clk  input  1  the block's single clock; all logic on rising edge.
REQ-005 clr  input  1  synchronous, active-high reset.
REQ-006 key_lvl  input  1  debounced key level, 1 = pressed; may be asynchronous to clk.
REQ-007 press_pulse  output  1  one-cycle strobe on press.
REQ-008 release_pulse  output  1  one-cycle strobe on release.
REQ-009 long_pulse  output  1  one-cycle strobe when the hold reaches LONG_MS.
REQ-010 repeat_pulse  output  1  one-cycle strobe every REPEAT_MS while in long hold.
REQ-011 key_held  output  1  level, 1 while FSM is in PRESSED or LONG.

Function
REQ-012 key_lvl SHALL pass through a 2-flop synchronizer; FSM uses synchronizer output only.
REQ-013 FSM states SHALL be IDLE, PRESSED, LONG; all outputs registered.
REQ-014 IDLE->PRESSED on synced level 1; press_pulse asserts 3 clk edges after the first edge sampling key_lvl=1.
REQ-015 On entry to PRESSED, the ms prescaler and hold counter SHALL restart from 0.
REQ-016 Prescaler counts 0..CLK_DIV-1 and emits ms_tick on wrap; ms_tick occurs only in PRESSED/LONG.
REQ-017 PRESSED: hold counter increments per ms_tick; on reaching LONG_MS -> LONG with long_pulse for one cycle, i.e., LONG_MS*CLK_DIV cycles after press_pulse.
REQ-018 LONG: repeat counter restarts at entry and increments per ms_tick; on reaching REPEAT_MS it emits repeat_pulse and resets to 0.
REQ-019 PRESSED or LONG -> IDLE on synced level 0, with release_pulse the same cycle as the state change.
REQ-020 Release and threshold on the same cycle: release wins; no long_pulse or repeat_pulse that cycle.
REQ-021 A 1-cycle key_lvl glitch captured by the synchronizer SHALL yield exactly one press_pulse and one release_pulse.
REQ-022 At most one of press_pulse, release_pulse, long_pulse, repeat_pulse is high in any cycle.
REQ-023 Counters are sized from the parameters via clog2 and never wrap unintentionally; hold counter stops at LONG_MS.

Reset
REQ-024 With clr=1 at a clk edge: state IDLE, all counters and synchronizer flops 0, all outputs 0 after that edge.
REQ-025 Reset mid-hold SHALL NOT produce release_pulse; a key still held after clr drops produces a fresh press_pulse 3 edges later.

Configuration
REQ-026 Macro KEY_EVENT_REPEAT_EN defined: repeat counter and repeat_pulse behave per REQ-018.
REQ-027 Macro KEY_EVENT_REPEAT_EN undefined: repeat counter not built; repeat_pulse tied 0; LONG only waits for release.

Structure
REQ-028 Shared package key_event_pkg holds the FSM state encoding (IDLE=2'd0, PRESSED=2'd1, LONG=2'd2) and default values for CLK_DIV, LONG_MS, REPEAT_MS.
REQ-029 Prescaler is sub-module key_event_tick (inputs clk, clr, restart, run; output ms_tick).

Verification (CLK_DIV=4, LONG_MS=3, REPEAT_MS=2 unless noted)
REQ-030 Short press: key_lvl high 10 cycles -> press_pulse at edge 3, release_pulse after low is synced, no long_pulse or repeat_pulse.
REQ-031 Long hold with KEY_EVENT_REPEAT_EN: key_lvl high 60 cycles -> long_pulse 12 cycles after press_pulse, then repeat_pulse every 8 cycles until release.
REQ-032 Same hold without KEY_EVENT_REPEAT_EN -> long_pulse at +12 cycles, repeat_pulse never asserts, release_pulse on release.
REQ-033 Release timed to reach the FSM on the long threshold cycle -> release_pulse only, no long_pulse.
REQ-034 clr high 2 cycles at cycle 20 of a hold -> outputs 0, no release_pulse; key still held -> new press_pulse 3 edges after clr drops.
REQ-035 1-cycle key_lvl glitch aligned to clk -> exactly one press_pulse followed by one release_pulse.

Source files
------------

// File: rtl/key_event_pkg.sv
// Shared definitions for the key event generator: FSM state encoding and
// default timing parameters (clk cycles per ms, long-press and repeat times).
// Pure declarations, no logic; imported by every key_event_* file.
package key_event_pkg;

  // Key FSM state encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } key_state_e;

  // Default timing: 100 MHz clk -> 1 ms tick, 800 ms long press, 150 ms repeat
  localparam int DEF_CLK_DIV   = 100000;
  localparam int DEF_LONG_MS   = 800;
  localparam int DEF_REPEAT_MS = 150;

endpackage

// File: rtl/key_event_if.sv
// Key event bundle: debounced key level in, one-cycle event strobes and held level out.
// Latency: none (wires only).
// Backpressure: none; strobes are fire-and-forget, the consumer must sample every cycle.
interface key_event_if;

  logic key_lvl;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic key_held;

  // Producer of the key level / consumer of events (e.g. a keypad scanner + UI logic)
  modport master (
    output key_lvl,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  repeat_pulse,
    input  key_held
  );

  // The event generator itself
  modport slave (
    input  key_lvl,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output repeat_pulse,
    output key_held
  );

endinterface

// File: rtl/key_event_tick.sv
// Millisecond prescaler: counts 0..CLK_DIV-1 while run is high, ms_tick on the wrap cycle.
// Latency: first ms_tick CLK_DIV cycles after the restart edge.
// Backpressure: none; held at 0 while run is low so ticks never appear outside a hold.
module key_event_tick
  import key_event_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic clr,
  input  logic restart,
  input  logic run,
  output logic ms_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear on restart or when idle, wrap at CLK_DIV-1
  always_comb begin
    cnt_d = cnt_q;
    if (restart || !run) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_TOP) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Prescaler register
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ms_tick = run && (cnt_q == CNT_TOP);

endmodule

// File: rtl/key_event_gen.sv
// Key event generator: press / release / long-press / auto-repeat strobes from a key level.
// Latency: press_pulse 3 edges after key_lvl is first sampled high; long_pulse LONG_MS*CLK_DIV after that.
// Backpressure: none; all outputs registered one-cycle strobes. Auto-repeat built only with KEY_EVENT_REPEAT_EN.
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int LONG_MS   = DEF_LONG_MS,
  parameter int REPEAT_MS = DEF_REPEAT_MS
) (
  input  logic        clk,
  input  logic        clr,
  key_event_if.slave  bus
);

  localparam int HOLD_W = $clog2(LONG_MS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_MS);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  // Two-flop synchronizer; key_lvl may come from another clock domain
  logic [1:0] sync_q, sync_d;
  logic       key_sync;

  // FSM state, hold counter and registered outputs
  key_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              held_q, held_d;

`ifdef KEY_EVENT_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_MS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_MS - 1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

  logic [REP_W-1:0] rep_q, rep_d;
  logic             repeat_q, repeat_d;
`endif

  logic restart;
  logic run;
  logic ms_tick;

  assign key_sync = sync_q[1];
  assign restart  = (state_q == IDLE) && key_sync;
  assign run      = (state_q != IDLE);

  key_event_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .clr     (clr),
    .restart (restart),
    .run     (run),
    .ms_tick (ms_tick)
  );

  // Shift the raw key level into the synchronizer
  always_comb begin
    sync_d = {sync_q[0], bus.key_lvl};
  end

  // Synchronizer flops
  always_ff @(posedge clk) begin
    if (clr) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Next-state and strobe decode; release takes priority over any ms threshold
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    held_d    = held_q;
`ifdef KEY_EVENT_REPEAT_EN
    rep_d     = rep_q;
    repeat_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (key_sync) begin
          state_d = PRESSED;
          hold_d  = '0;
          press_d = 1'b1;
          held_d  = 1'b1;
        end
      end
      PRESSED: begin
        if (!key_sync) begin
          state_d   = IDLE;
          release_d = 1'b1;
          held_d    = 1'b0;
        end else if (ms_tick) begin
          if (hold_q == HOLD_LAST) begin
            // Hold counter parks at LONG_MS once the long press fires
            state_d = LONG;
            hold_d  = HOLD_MAX;
            long_d  = 1'b1;
`ifdef KEY_EVENT_REPEAT_EN
            rep_d   = '0;
`endif
          end else begin
            hold_d = hold_q + HOLD_ONE;
          end
        end
      end
      LONG: begin
        if (!key_sync) begin
          state_d   = IDLE;
          release_d = 1'b1;
          held_d    = 1'b0;
        end
`ifdef KEY_EVENT_REPEAT_EN
        else if (ms_tick) begin
          if (rep_q == REP_LAST) begin
            rep_d    = '0;
            repeat_d = 1'b1;
          end else begin
            rep_d = rep_q + REP_ONE;
          end
        end
`endif
      end
      default: begin
        state_d = IDLE;
        held_d  = 1'b0;
      end
    endcase
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
      rep_q     <= '0;
      repeat_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      held_q    <= held_d;
`ifdef KEY_EVENT_REPEAT_EN
      rep_q     <= rep_d;
      repeat_q  <= repeat_d;
`endif
    end
  end

  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.long_pulse    = long_q;
  assign bus.key_held      = held_q;
`ifdef KEY_EVENT_REPEAT_EN
  assign bus.repeat_pulse  = repeat_q;
`else
  assign bus.repeat_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_gen.sv
// Bench for key_event_gen with CLK_DIV=4, LONG_MS=3, REPEAT_MS=2.
// Reference model tracks how long the synchronised key level has been high
// and derives every expected strobe from that run length.
module tb_key_event_gen;
  import key_event_pkg::*;

  localparam int CLK_DIV    = 4;
  localparam int LONG_MS    = 3;
  localparam int REPEAT_MS  = 2;
  localparam int LONG_RUN   = 1 + LONG_MS * CLK_DIV;
  localparam int REP_PERIOD = REPEAT_MS * CLK_DIV;
`ifdef KEY_EVENT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  key_event_if bus ();

  key_event_gen #(
    .CLK_DIV   (CLK_DIV),
    .LONG_MS   (LONG_MS),
    .REPEAT_MS (REPEAT_MS)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit d1, d2;
  int run_len;
  bit e_press, e_rel, e_long, e_rep, e_held;

  // Pulses observed in the current scenario
  int n_press, n_rel, n_long, n_rep;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_counts();
    n_press = 0;
    n_rel   = 0;
    n_long  = 0;
    n_rep   = 0;
  endtask

  // One clock: drive inputs, advance model at the edge, check on the falling edge
  task automatic step(input logic key, input logic rst);
    bit lvl;
    int prev;
    bus.key_lvl = key;
    clr         = rst;
    @(posedge clk);
    if (rst) begin
      d1 = 0; d2 = 0; run_len = 0;
      e_press = 0; e_rel = 0; e_long = 0; e_rep = 0; e_held = 0;
    end else begin
      lvl     = d2;
      d2      = d1;
      d1      = key;
      prev    = run_len;
      run_len = lvl ? run_len + 1 : 0;
      e_press = lvl && (prev == 0);
      e_rel   = !lvl && (prev != 0);
      e_long  = (run_len == LONG_RUN);
      e_rep   = REP_EN && (run_len > LONG_RUN) && (((run_len - LONG_RUN) % REP_PERIOD) == 0);
      e_held  = lvl;
    end
    @(negedge clk);
    check_val("press_pulse",   32'(bus.press_pulse),   32'(e_press));
    check_val("release_pulse", 32'(bus.release_pulse), 32'(e_rel));
    check_val("long_pulse",    32'(bus.long_pulse),    32'(e_long));
    check_val("repeat_pulse",  32'(bus.repeat_pulse),  32'(e_rep));
    check_val("key_held",      32'(bus.key_held),      32'(e_held));
    check_val("onehot", 32'($countones({bus.press_pulse, bus.release_pulse,
                                         bus.long_pulse, bus.repeat_pulse}) <= 1), 32'd1);
    n_press += int'(bus.press_pulse === 1'b1);
    n_rel   += int'(bus.release_pulse === 1'b1);
    n_long  += int'(bus.long_pulse === 1'b1);
    n_rep   += int'(bus.repeat_pulse === 1'b1);
  endtask

  task automatic hold(input int n, input logic key, input logic rst);
    for (int i = 0; i < n; i++) step(key, rst);
  endtask

  task automatic check_counts(input string tag, input int p, input int r, input int l, input int rp);
    check_val({tag, "_press_cnt"},   32'(n_press), 32'(p));
    check_val({tag, "_release_cnt"}, 32'(n_rel),   32'(r));
    check_val({tag, "_long_cnt"},    32'(n_long),  32'(l));
    check_val({tag, "_repeat_cnt"},  32'(n_rep),   32'(rp));
  endtask

  initial begin
    bus.key_lvl = 1'b0;
    clr         = 1'b1;
    d1 = 0; d2 = 0; run_len = 0;
    clear_counts();

    // Reset state
    hold(2, 1'b0, 1'b1);
    hold(2, 1'b0, 1'b0);

    // Short press
    clear_counts();
    hold(10, 1'b1, 1'b0);
    hold(8, 1'b0, 1'b0);
    check_counts("short", 1, 1, 0, 0);

    // Long hold, repeats at run lengths 21,29,37,45,53 when enabled
    clear_counts();
    hold(60, 1'b1, 1'b0);
    hold(8, 1'b0, 1'b0);
    check_counts("long", 1, 1, 1, REP_EN ? 5 : 0);

    // Release reaching the FSM on the long threshold cycle
    clear_counts();
    hold(LONG_MS * CLK_DIV, 1'b1, 1'b0);
    hold(8, 1'b0, 1'b0);
    check_counts("thresh_rel", 1, 1, 0, 0);

    // One cycle longer: long press, then release
    clear_counts();
    hold(LONG_MS * CLK_DIV + 1, 1'b1, 1'b0);
    hold(8, 1'b0, 1'b0);
    check_counts("thresh_long", 1, 1, 1, 0);

    // Reset in the middle of a hold, key still held afterwards
    clear_counts();
    hold(20, 1'b1, 1'b0);
    hold(2, 1'b1, 1'b1);
    hold(10, 1'b1, 1'b0);
    hold(8, 1'b0, 1'b0);
    check_counts("mid_reset", 2, 1, 1, 0);

    // Single-cycle glitch
    clear_counts();
    hold(1, 1'b1, 1'b0);
    hold(8, 1'b0, 1'b0);
    check_counts("glitch", 1, 1, 0, 0);

    // Random holds, gaps and occasional resets
    for (int it = 0; it < 60; it++) begin
      hold(int'($urandom_range(1, 40)), 1'b1, 1'b0);
      if ($urandom_range(0, 7) == 0) hold(int'($urandom_range(1, 2)), $urandom_range(0, 1) != 0, 1'b1);
      hold(int'($urandom_range(1, 6)), 1'b0, 1'b0);
    end
    hold(6, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
